// File: rtl/cache_burst_ram_if.sv
// rtl/cache_burst_ram_if.sv - Avalon-MM burst bus between the cache master port and the backing RAM
interface cache_burst_ram_if #(
  parameter int BURST_COUNT_WIDTH = 8
);
  logic [31:0]                  address;
  logic [3:0]                   byteEnable;
  logic                         read;
  logic                         write;
  logic [31:0]                  writeData;
  logic                         beginBurstTransfer;
  logic [BURST_COUNT_WIDTH-1:0] burstCount;
  logic                         waitRequest;
  logic [31:0]                  readData;
  logic                         readDataValid;

  modport master (
    output address, byteEnable, read, write, writeData, beginBurstTransfer, burstCount,
    input  waitRequest, readData, readDataValid
  );

  modport slave (
    input  address, byteEnable, read, write, writeData, beginBurstTransfer, burstCount,
    output waitRequest, readData, readDataValid
  );
endinterface

// File: rtl/cache_burst_ram.sv
// rtl/cache_burst_ram.sv - burst slave RAM backing cache line fills and write-backs
module cache_burst_ram #(
  parameter int ADDR_WIDTH        = 12,
  parameter int BURST_COUNT_WIDTH = 8,
  parameter int READ_LATENCY      = 2
) (
  input  logic               clk,
  input  logic               rest,
  cache_burst_ram_if.slave   s0,
  output logic               err_protocol
);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_ISSUE, RD_DRAIN} stateE;

  stateE state;
  stateE stateNext;

  logic [31:0]                  mem [0:(1<<ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0]        curAddr;
  logic [BURST_COUNT_WIDTH-1:0] remaining;
  logic [ADDR_WIDTH-1:0]        reqWord;
  logic [BURST_COUNT_WIDTH-1:0] effCount;
  logic                         upstreamBusy;
  logic                         protoErr;

  // FSM output decode
  logic                  waitReq;
  logic                  issueValid;
  logic [ADDR_WIDTH-1:0] issueAddr;
  logic [31:0]           issueData;
  logic                  wrEn;
  logic [ADDR_WIDTH-1:0] wrAddr;

  // read pipeline; stage READ_LATENCY drives the bus and holds its data between beats
  logic [READ_LATENCY:1] pipeValid;
  logic [31:0]           pipeData [1:READ_LATENCY];

  // address bits outside the word index carry no meaning for this memory
  logic unusedAddrBits;
  assign unusedAddrBits = &{1'b0, s0.address[31:ADDR_WIDTH+2], s0.address[1:0]};

  assign reqWord  = s0.address[ADDR_WIDTH+1:2];
  // a zero burst count is served as a single beat
  assign effCount = (s0.burstCount == '0) ? BURST_COUNT_WIDTH'(1) : s0.burstCount;

  // read drain is complete once only the output stage can still hold a beat
  always_comb begin
    upstreamBusy = 1'b0;
    for (int i = 1; i < READ_LATENCY; i++) begin
      upstreamBusy = upstreamBusy | pipeValid[i];
    end
  end

  // protocol violations: read+write collision, zero burst count, stray read/start in a write burst
  always_comb begin
    protoErr = 1'b0;
    if (state == IDLE) begin
      protoErr = (s0.read && s0.write) || ((s0.read || s0.write) && (s0.burstCount == '0));
    end else if (state == WR_BURST) begin
      protoErr = s0.read || s0.beginBurstTransfer;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rest) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (s0.write) begin
          stateNext = (effCount == BURST_COUNT_WIDTH'(1)) ? IDLE : WR_BURST;
        end else if (s0.read) begin
          // the first beat issues on acceptance, so a one-beat read only needs to drain
          stateNext = (effCount == BURST_COUNT_WIDTH'(1)) ? RD_DRAIN : RD_ISSUE;
        end
      end
      WR_BURST: begin
        if (s0.write && (remaining == BURST_COUNT_WIDTH'(1))) stateNext = IDLE;
      end
      RD_ISSUE: begin
        if (remaining == BURST_COUNT_WIDTH'(1)) stateNext = RD_DRAIN;
      end
      RD_DRAIN: begin
        if (!upstreamBusy) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // outputs and datapath strobes decoded from the current state
  always_comb begin
    waitReq    = 1'b0;
    issueValid = 1'b0;
    issueAddr  = curAddr;
    wrEn       = 1'b0;
    wrAddr     = curAddr;
    case (state)
      IDLE: begin
        wrEn       = s0.write;
        wrAddr     = reqWord;
        issueValid = s0.read && !s0.write;
        issueAddr  = reqWord;
      end
      WR_BURST: begin
        wrEn = s0.write;
      end
      RD_ISSUE: begin
        waitReq    = 1'b1;
        issueValid = 1'b1;
      end
      RD_DRAIN: begin
        waitReq = 1'b1;
      end
      default: waitReq = 1'b0;
    endcase
    issueData = mem[issueAddr];
  end

  assign s0.waitRequest   = waitReq;
  assign s0.readData      = pipeData[READ_LATENCY];
  assign s0.readDataValid = pipeValid[READ_LATENCY];

  // memory array is never cleared; only enabled byte lanes are written
  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int b = 0; b < 4; b++) begin
        if (s0.byteEnable[b]) mem[wrAddr][8*b +: 8] <= s0.writeData[8*b +: 8];
      end
    end
  end

  // burst address/beat counters and the sticky error flag
  always_ff @(posedge clk) begin
    if (rest) begin
      curAddr      <= '0;
      remaining    <= '0;
      err_protocol <= 1'b0;
    end else begin
      if (state == IDLE && (s0.read || s0.write)) begin
        curAddr   <= reqWord + ADDR_WIDTH'(1);
        remaining <= effCount - BURST_COUNT_WIDTH'(1);
      end else if ((state == WR_BURST && s0.write) || state == RD_ISSUE) begin
        curAddr   <= curAddr + ADDR_WIDTH'(1);
        remaining <= remaining - BURST_COUNT_WIDTH'(1);
      end
      if (protoErr) err_protocol <= 1'b1;
    end
  end

  genvar g;
  for (g = 1; g <= READ_LATENCY; g++) begin : gStage
    // each stage shifts valid every cycle but only captures data with a valid beat
    always_ff @(posedge clk) begin
      if (rest) begin
        pipeValid[g] <= 1'b0;
        pipeData[g]  <= '0;
      end else begin
        if (g == 1) begin
          pipeValid[g] <= issueValid;
          if (issueValid) pipeData[g] <= issueData;
        end else begin
          pipeValid[g] <= pipeValid[g-1];
          if (pipeValid[g-1]) pipeData[g] <= pipeData[g-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_burst_ram.sv
// tb/tb_cache_burst_ram.sv - directed self-checking bench for cache_burst_ram
module tb_cache_burst_ram;

  logic clk;
  logic rest;
  logic errProtocol;
  int   checks;
  int   failures;
  logic [31:0] expData [0:7];

  cache_burst_ram_if #(.BURST_COUNT_WIDTH(8)) s0 ();

  cache_burst_ram #(
    .ADDR_WIDTH(12),
    .BURST_COUNT_WIDTH(8),
    .READ_LATENCY(2)
  ) dut (
    .clk(clk),
    .rest(rest),
    .s0(s0),
    .err_protocol(errProtocol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic busIdle();
    s0.address            = '0;
    s0.byteEnable         = '0;
    s0.read               = 1'b0;
    s0.write              = 1'b0;
    s0.writeData          = '0;
    s0.beginBurstTransfer = 1'b0;
    s0.burstCount         = '0;
  endtask

  task automatic wrBeat(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                        input logic [7:0] cnt, input logic first);
    s0.address            = addr;
    s0.writeData          = data;
    s0.byteEnable         = be;
    s0.burstCount         = cnt;
    s0.beginBurstTransfer = first;
    s0.write              = 1'b1;
    check("wr_wait", {31'd0, s0.waitRequest}, 32'd0);
    tick();
    s0.write              = 1'b0;
    s0.beginBurstTransfer = 1'b0;
  endtask

  // read with fixed latency 2: beats expected at acceptance+2 .. acceptance+1+n
  task automatic rdBurst(input logic [31:0] addr, input logic [7:0] cnt, input int n);
    s0.address            = addr;
    s0.burstCount         = cnt;
    s0.beginBurstTransfer = 1'b1;
    s0.read               = 1'b1;
    check("rd_accept_wait", {31'd0, s0.waitRequest}, 32'd0);
    tick();
    s0.read               = 1'b0;
    s0.beginBurstTransfer = 1'b0;
    check("rd_lat1_valid", {31'd0, s0.readDataValid}, 32'd0);
    check("rd_lat1_wait", {31'd0, s0.waitRequest}, 32'd1);
    tick();
    for (int k = 0; k < n; k++) begin
      check("rd_beat_valid", {31'd0, s0.readDataValid}, 32'd1);
      check("rd_beat_data", s0.readData, expData[k]);
      check("rd_beat_wait", {31'd0, s0.waitRequest}, 32'd1);
      tick();
    end
    check("rd_done_valid", {31'd0, s0.readDataValid}, 32'd0);
    check("rd_done_wait", {31'd0, s0.waitRequest}, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    busIdle();
    rest = 1'b1;
    tick();
    tick();
    check("rst_wait", {31'd0, s0.waitRequest}, 32'd0);
    check("rst_valid", {31'd0, s0.readDataValid}, 32'd0);
    check("rst_data", s0.readData, 32'd0);
    check("rst_err", {31'd0, errProtocol}, 32'd0);
    rest = 1'b0;
    tick();

    // single write, then read on the very next cycle sees the new word
    wrBeat(32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 8'd1, 1'b1);
    expData[0] = 32'hDEAD_BEEF;
    rdBurst(32'h0000_0040, 8'd1, 1);
    tick();
    check("hold_data", s0.readData, 32'hDEAD_BEEF);

    // byte lanes
    wrBeat(32'h0000_0080, 32'h1122_3344, 4'hF, 8'd1, 1'b1);
    wrBeat(32'h0000_0080, 32'hAABB_CCDD, 4'h5, 8'd1, 1'b1);
    expData[0] = 32'h11BB_33DD;
    rdBurst(32'h0000_0080, 8'd1, 1);

    // cache line fill with a paused beat
    wrBeat(32'h0000_0100, 32'd1, 4'hF, 8'd4, 1'b1);
    wrBeat(32'h0000_0100, 32'd2, 4'hF, 8'd4, 1'b0);
    check("pause_wait", {31'd0, s0.waitRequest}, 32'd0);
    tick();
    wrBeat(32'h0000_0100, 32'd3, 4'hF, 8'd4, 1'b0);
    wrBeat(32'h0000_0100, 32'd4, 4'hF, 8'd4, 1'b0);
    expData[0] = 32'd1; expData[1] = 32'd2; expData[2] = 32'd3; expData[3] = 32'd4;
    rdBurst(32'h0000_0100, 8'd4, 4);
    check("line_err", {31'd0, errProtocol}, 32'd0);

    // wrap-around at the top of the 4K-word array
    wrBeat(32'h0000_3FF8, 32'hA000_0FFE, 4'hF, 8'd3, 1'b1);
    wrBeat(32'h0000_3FF8, 32'hA000_0FFF, 4'hF, 8'd3, 1'b0);
    wrBeat(32'h0000_3FF8, 32'hA000_0000, 4'hF, 8'd3, 1'b0);
    expData[0] = 32'hA000_0FFE; expData[1] = 32'hA000_0FFF; expData[2] = 32'hA000_0000;
    rdBurst(32'h0000_3FF8, 8'd3, 3);
    expData[0] = 32'hA000_0000;
    rdBurst(32'h0000_0000, 8'd1, 1);
    check("wrap_err", {31'd0, errProtocol}, 32'd0);

    // reset during the third cycle of an 8-beat read
    s0.address    = 32'h0000_0100;
    s0.burstCount = 8'd8;
    s0.read       = 1'b1;
    tick();
    s0.read = 1'b0;
    tick();
    check("midrst_first_valid", {31'd0, s0.readDataValid}, 32'd1);
    rest = 1'b1;
    tick();
    check("midrst_valid", {31'd0, s0.readDataValid}, 32'd0);
    check("midrst_wait", {31'd0, s0.waitRequest}, 32'd0);
    rest = 1'b0;
    tick();
    check("midrst_idle_valid", {31'd0, s0.readDataValid}, 32'd0);
    expData[0] = 32'hDEAD_BEEF;
    rdBurst(32'h0000_0040, 8'd1, 1);

    // read and write together: write lands, read dropped, error sticks
    s0.address    = 32'h0000_0200;
    s0.writeData  = 32'h5A5A_1234;
    s0.byteEnable = 4'hF;
    s0.burstCount = 8'd1;
    s0.read       = 1'b1;
    s0.write      = 1'b1;
    tick();
    busIdle();
    check("rw_err", {31'd0, errProtocol}, 32'd1);
    check("rw_wait", {31'd0, s0.waitRequest}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      check("rw_no_valid", {31'd0, s0.readDataValid}, 32'd0);
      tick();
    end
    expData[0] = 32'h5A5A_1234;
    rdBurst(32'h0000_0200, 8'd1, 1);
    check("rw_err_sticky", {31'd0, errProtocol}, 32'd1);
    rest = 1'b1;
    tick();
    rest = 1'b0;
    check("err_cleared", {31'd0, errProtocol}, 32'd0);
    tick();

    // zero burst count serves exactly one beat and flags an error
    expData[0] = 32'd1;
    rdBurst(32'h0000_0100, 8'd0, 1);
    check("zero_cnt_err", {31'd0, errProtocol}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
